error_feedback: RTL
===================

# error_feedback

Output-end responder for the neuron forward/backward protocol. It consumes a node's 8-bit forward activation and a matching 8-bit target and forms the signed error `target - activation`. In training it returns the error to the node on the 16-bit backward channel. Optionally it accumulates a batch squared-error metric. It sits after the last layer and closes the training loop.

## Interface
Parameters:
- `SHIFT`, default 0: left shift applied to the error before it is sent backward; legal range 0..7.
- `BATCH`, default 16: number of samples per metric report; legal range 1..65535.

Ports:
- `clock`  in  1: single clock for the block.
- `reset`  in  1: asynchronous, active-low reset.
- `train`  in  1: training mode, sampled in DIFF.
- `input_forward_valid`  in  1: activation valid.
- `input_forward_data`  in  8: unsigned activation.
- `input_forward_ready`  out  1: activation accepted.
- `target_valid`  in  1: target valid.
- `target_data`  in  8: unsigned target.
- `target_ready`  out  1: target accepted.
- `output_backward_valid`  out  1: error valid.
- `output_backward_data`  out  16: signed error to the node's backward input.
- `output_backward_ready`  in  1: error accepted.
- `metric_valid`  out  1: batch metric valid (LOSS_METRIC_EN only).
- `metric_data`  out  32: unsigned sum of squared errors (LOSS_METRIC_EN only).
- `metric_ready`  in  1: metric accepted (LOSS_METRIC_EN only).

## Operation
- States: LOAD, DIFF, SEND, REPORT.
- LOAD:
  - `input_forward_ready = (state==LOAD) & !have_act`; `target_ready = (state==LOAD) & !have_tgt`.
  - Each handshake captures its data and sets its held flag.
  - The two channels are independent, in any order, including the same cycle.
  - When both flags are set, go to DIFF.
- DIFF:
  - `err = (signed'{8'b0,target} - signed'{8'b0,act})`, 16-bit signed, range -255..255.
  - `output_backward_data <= err <<< SHIFT`. No overflow is possible: |255·128| < 2^15.
  - Clear both held flags.
  - If `train`, set `output_backward_valid` and go to SEND.
  - Otherwise go to REPORT when a report is due, else to LOAD.
- SEND: hold valid and data stable until `output_backward_ready`. On the handshake, clear valid and go to REPORT when a report is due, else to LOAD.
- Metric (LOSS_METRIC_EN):
  - In DIFF, `acc += err*err`, using the unshifted error; `count += 1`.
  - A report is due when the incremented count equals BATCH.
  - The 32-bit accumulator cannot overflow: 65535·65025 < 2^32.
- REPORT:
  - `metric_valid = 1` and `metric_data = acc`, both held stable.
  - On `metric_ready`: clear `acc` and `count`, deassert valid, go to LOAD.
- Metric samples are counted in both train and inference mode.

## Timing
- Reset: state LOAD, held flags 0, `output_backward_valid = 0`, `output_backward_data = 0`, `metric_valid = 0`, `metric_data = 0`, accumulator 0, count 0, `input_forward_ready = 1`, `target_ready = 1`.
- Latency: completing handshake at cycle c puts DIFF in c+1 and `output_backward_valid` high in c+2.
- Zero-wait throughput (train): one sample per 3 cycles (LOAD, DIFF, SEND).
- Both readies are low outside LOAD. Inputs offered early are held off by their sources and never dropped.
- `output_backward_ready` may be high before valid; the handshake completes in the first SEND cycle.
- `train` is sampled only in DIFF. Changing it elsewhere has no effect on the sample in flight.
- Reset mid-operation in any state returns to the reset values at once. Held inputs, pending error and the partial batch are discarded.

## Configuration
- `LOSS_METRIC_EN` defined:
  - The accumulator, counter and REPORT state are built.
  - `metric_*` behave as described in Operation.
- Not defined:
  - No accumulator, counter or REPORT state.
  - `metric_valid` is tied 0, `metric_data` is tied 0, and `metric_ready` is ignored.
  - SEND and DIFF always return to LOAD.
  - Ports are identical in both builds.

## Test plan
- SHIFT=0, train=1: activation 0x80, target 0xFF same cycle -> `output_backward_data = 0x007F`; valid exactly 2 cycles after the handshake.
- SHIFT=0: target arrives 4 cycles after activation 200, target 0 -> data `0xFF38` (-200); `input_forward_ready` stays low while waiting.
- SHIFT=7: activation 0, target 255 -> `0x7F80`. Then activation 255, target 0 -> `0x8080`.
- train=0: activation 10, target 20 -> `output_backward_valid` never asserts; back in LOAD 2 cycles after the handshake.
- Backpressure: `output_backward_ready` low 5 cycles in SEND -> valid and data stable, both input readies low; LOAD on the cycle after the handshake.
- LOSS_METRIC_EN, BATCH=2:
  - Errors +3 then -4 -> `metric_data = 25`, held through 3 cycles of `metric_ready = 0`.
  - Assert `reset` during REPORT -> `metric_valid = 0`; the next batch starts from 0.

Source files
------------

// File: rtl/error_feedback.sv
// Output-end error responder: pairs an activation with its target, returns target-activation on the backward channel.
// Optional batch squared-error metric is built when LOSS_METRIC_EN is defined.
module error_feedback #(
    parameter int SHIFT = 0,
    parameter int BATCH = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        train,
    input  logic        input_forward_valid,
    input  logic [7:0]  input_forward_data,
    output logic        input_forward_ready,
    input  logic        target_valid,
    input  logic [7:0]  target_data,
    output logic        target_ready,
    output logic        output_backward_valid,
    output logic [15:0] output_backward_data,
    input  logic        output_backward_ready,
    output logic        metric_valid,
    output logic [31:0] metric_data,
    input  logic        metric_ready
);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        DIFF   = 2'd1,
        SEND   = 2'd2,
        REPORT = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               have_act_q, have_act_d;
    logic               have_tgt_q, have_tgt_d;
    logic [7:0]         act_q, act_d;
    logic [7:0]         tgt_q, tgt_d;
    logic               bwd_valid_q, bwd_valid_d;
    logic [15:0]        bwd_data_q, bwd_data_d;
    logic signed [15:0] err_s;
    logic               report_due_s;

    assign err_s = $signed({8'h00, tgt_q}) - $signed({8'h00, act_q});

    assign input_forward_ready   = (state_q == LOAD) && !have_act_q;
    assign target_ready          = (state_q == LOAD) && !have_tgt_q;
    assign output_backward_valid = bwd_valid_q;
    assign output_backward_data  = bwd_data_q;

`ifdef LOSS_METRIC_EN
    localparam logic [15:0] BATCH_C = 16'(BATCH);

    logic [31:0]        acc_q, acc_d;
    logic [15:0]        count_q, count_d;
    logic               metric_valid_q, metric_valid_d;
    logic [31:0]        metric_data_q, metric_data_d;
    logic [15:0]        count_next_s;
    logic signed [31:0] err_w_s;
    logic [31:0]        sq_s;

    // The metric uses the unshifted error; the square always fits in 17 bits.
    assign err_w_s      = 32'(err_s);
    assign sq_s         = err_w_s * err_w_s;
    assign count_next_s = (state_q == DIFF) ? (count_q + 16'd1) : count_q;
    assign report_due_s = (count_next_s == BATCH_C);
    assign metric_valid = metric_valid_q;
    assign metric_data  = metric_data_q;

    // Metric accumulation and report holding register updates
    always_comb begin
        acc_d          = acc_q;
        count_d        = count_q;
        metric_valid_d = metric_valid_q;
        metric_data_d  = metric_data_q;
        if (state_q == DIFF) begin
            acc_d   = acc_q + sq_s;
            count_d = count_next_s;
        end else if ((state_q == REPORT) && metric_ready) begin
            acc_d          = 32'd0;
            count_d        = 16'd0;
            metric_valid_d = 1'b0;
            metric_data_d  = 32'd0;
        end else begin
            acc_d = acc_q;
        end
        if ((state_q != REPORT) && (state_d == REPORT)) begin
            metric_valid_d = 1'b1;
            metric_data_d  = acc_d;
        end else begin
            metric_valid_d = metric_valid_d;
        end
    end

    // Metric state registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_q          <= 32'd0;
            count_q        <= 16'd0;
            metric_valid_q <= 1'b0;
            metric_data_q  <= 32'd0;
        end else begin
            acc_q          <= acc_d;
            count_q        <= count_d;
            metric_valid_q <= metric_valid_d;
            metric_data_q  <= metric_data_d;
        end
    end
`else
    logic unused_metric_ready_s;

    assign unused_metric_ready_s = metric_ready;
    assign report_due_s          = 1'b0;
    assign metric_valid          = 1'b0;
    assign metric_data           = 32'd0;
`endif

    // Next-state and datapath control for the sample loop
    always_comb begin
        state_d     = state_q;
        have_act_d  = have_act_q;
        have_tgt_d  = have_tgt_q;
        act_d       = act_q;
        tgt_d       = tgt_q;
        bwd_valid_d = bwd_valid_q;
        bwd_data_d  = bwd_data_q;
        case (state_q)
            LOAD: begin
                if (input_forward_valid && !have_act_q) begin
                    have_act_d = 1'b1;
                    act_d      = input_forward_data;
                end else begin
                    have_act_d = have_act_q;
                end
                if (target_valid && !have_tgt_q) begin
                    have_tgt_d = 1'b1;
                    tgt_d      = target_data;
                end else begin
                    have_tgt_d = have_tgt_q;
                end
                // Leave on the completing handshake so DIFF follows immediately.
                if (have_act_d && have_tgt_d) begin
                    state_d = DIFF;
                end else begin
                    state_d = LOAD;
                end
            end
            DIFF: begin
                have_act_d = 1'b0;
                have_tgt_d = 1'b0;
                bwd_data_d = err_s <<< SHIFT;
                if (train) begin
                    bwd_valid_d = 1'b1;
                    state_d     = SEND;
                end else begin
                    state_d = report_due_s ? REPORT : LOAD;
                end
            end
            SEND: begin
                if (output_backward_ready) begin
                    bwd_valid_d = 1'b0;
                    state_d     = report_due_s ? REPORT : LOAD;
                end else begin
                    state_d = SEND;
                end
            end
`ifdef LOSS_METRIC_EN
            REPORT: begin
                if (metric_ready) begin
                    state_d = LOAD;
                end else begin
                    state_d = REPORT;
                end
            end
`endif
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // Sample-loop state registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= LOAD;
            have_act_q  <= 1'b0;
            have_tgt_q  <= 1'b0;
            act_q       <= 8'd0;
            tgt_q       <= 8'd0;
            bwd_valid_q <= 1'b0;
            bwd_data_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            have_act_q  <= have_act_d;
            have_tgt_q  <= have_tgt_d;
            act_q       <= act_d;
            tgt_q       <= tgt_d;
            bwd_valid_q <= bwd_valid_d;
            bwd_data_q  <= bwd_data_d;
        end
    end

endmodule
